// File: rtl/param_alu_pipe_if.sv
// ============================================================================
// Module  : param_alu_pipe_if
// Purpose : Operand-issue and result handshake bundle for param_alu_pipe.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface param_alu_pipe_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_ctrl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             overflow;
  logic             zero;

  // master = operand issuer / result consumer; slave = the ALU pipe
  modport master (
    output in_valid, a, b, alu_ctrl, out_ready,
    input  in_ready, out_valid, s, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, alu_ctrl, out_ready,
    output in_ready, out_valid, s, overflow, zero
  );
endinterface

`default_nettype wire

// File: rtl/param_alu_pipe.sv
// ============================================================================
// Module  : param_alu_pipe
// Purpose : Two-stage valid/ready pipelined ALU; define ALU_SAT_EN to make
//           add/sub/inc/dec saturate instead of wrap.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module param_alu_pipe #(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  param_alu_pipe_if.slave   bus
);

  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_SUB  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_DEC  = 4'b0100;
  localparam logic [3:0] OP_INC  = 4'b0101;
  localparam logic [3:0] OP_NOT  = 4'b0110;
  localparam logic [3:0] OP_LSL  = 4'b1000;
  localparam logic [3:0] OP_SLTE = 4'b1001;
  localparam logic [3:0] OP_LSR  = 4'b1010;
  localparam logic [3:0] OP_ASL  = 4'b1100;
  localparam logic [3:0] OP_ASR  = 4'b1110;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

`ifdef ALU_SAT_EN
  // Overflow direction always follows the sign of A for add/sub/inc/dec.
  function automatic logic [WIDTH-1:0] saturate(input logic neg);
    return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
`endif

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             s2_advance;
  logic             in_ready;
  logic [WIDTH-1:0] res;
  logic             ovf;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] asl_back;
  logic [SHW-1:0]   shamt;

  assign s2_advance = !s2_valid_q || bus.out_ready;
  assign in_ready   = !s1_valid_q || s2_advance;

  // Stage-2 datapath works only from stage-1 registers: no input-to-output path.
  always_comb begin
    res      = '0;
    ovf      = 1'b0;
    shamt    = b_q[SHW-1:0];
    opnd     = (op_q == OP_INC || op_q == OP_DEC) ? ONE : b_q;
    asl_back = '0;
    case (op_q)
      OP_ADD, OP_INC: begin
        res = a_q + opnd;
        ovf = (a_q[MSB] == opnd[MSB]) && (res[MSB] != a_q[MSB]);
`ifdef ALU_SAT_EN
        if (ovf) res = saturate(a_q[MSB]);
`endif
      end
      OP_SUB, OP_DEC: begin
        res = a_q - opnd;
        ovf = (a_q[MSB] != opnd[MSB]) && (res[MSB] != a_q[MSB]);
`ifdef ALU_SAT_EN
        if (ovf) res = saturate(a_q[MSB]);
`endif
      end
      OP_OR:   res = a_q | b_q;
      OP_AND:  res = a_q & b_q;
      OP_NOT:  res = ~a_q;
      OP_LSL:  res = a_q << shamt;
      OP_LSR:  res = a_q >> shamt;
      OP_ASL: begin
        res      = a_q << shamt;
        asl_back = $signed(res) >>> shamt;
        ovf      = (asl_back != a_q);
      end
      OP_ASR:  res = $signed(a_q) >>> shamt;
      OP_SLTE: res = ($signed(a_q) <= $signed(b_q)) ? ONE : '0;
      default: res = '0;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    s2_valid_d = s2_valid_q;
    s_d        = s_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;

    if (s2_advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s_d    = res;
        ovf_d  = ovf;
        zero_d = (res == '0);
      end
    end

    if (in_ready) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        a_d  = bus.a;
        b_d  = bus.b;
        op_d = bus.alu_ctrl;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      s2_valid_q <= 1'b0;
      s_q        <= '0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      s2_valid_q <= s2_valid_d;
      s_q        <= s_d;
      ovf_q      <= ovf_d;
      zero_q     <= zero_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.s         = s_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_param_alu_pipe.sv
// ============================================================================
// Module  : tb_param_alu_pipe
// Purpose : Directed-vector bench for param_alu_pipe (WIDTH = 16).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_param_alu_pipe;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  param_alu_pipe_if #(.WIDTH(16)) bus ();

  param_alu_pipe #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one bundle with no backpressure and check it 2 edges later.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] s_exp, input logic ovf_exp);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.alu_ctrl  = op;
    bus.a         = a;
    bus.b         = b;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    check({tag, "_lat1"}, bus.out_valid, 1'b0);
    @(posedge clk); #1;
    check({tag, "_valid"}, bus.out_valid, 1'b1);
    check({tag, "_s"},     bus.s,         s_exp);
    check({tag, "_ovf"},   bus.overflow,  ovf_exp);
    check({tag, "_zero"},  bus.zero,      s_exp == 16'h0);
  endtask

  initial begin
    logic [15:0] exp_q[$];
    logic [15:0] held;
    logic [15:0] e;
    int          issued;
    int          recv;
    int          stall;
    bit          seen;

    n_tests       = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.alu_ctrl  = '0;

    #1;
    check("rst_valid", bus.out_valid, 1'b0);
    check("rst_s",     bus.s,         16'h0);
    check("rst_ovf",   bus.overflow,  1'b0);
    check("rst_zero",  bus.zero,      1'b0);
    check("rst_ready", bus.in_ready,  1'b1);

    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef ALU_SAT_EN
    run_op("add_ovf", 4'b0001, 16'h53DB, 16'h55C6, 16'h7FFF, 1'b1);
    run_op("dec_min", 4'b0100, 16'h8000, 16'h0000, 16'h8000, 1'b1);
    run_op("inc_max", 4'b0101, 16'h7FFF, 16'h0000, 16'h7FFF, 1'b1);
`else
    run_op("add_ovf", 4'b0001, 16'h53DB, 16'h55C6, 16'hA9A1, 1'b1);
    run_op("dec_min", 4'b0100, 16'h8000, 16'h0000, 16'h7FFF, 1'b1);
    run_op("inc_max", 4'b0101, 16'h7FFF, 16'h0000, 16'h8000, 1'b1);
`endif
    run_op("sub_eq",   4'b0000, 16'h175D, 16'h175D, 16'h0000, 1'b0);
    run_op("add_ok",   4'b0001, 16'h0123, 16'h0456, 16'h0579, 1'b0);
    run_op("sub_neg",  4'b0000, 16'h0003, 16'h0005, 16'hFFFE, 1'b0);
    run_op("or",       4'b0010, 16'h00F0, 16'h0F0F, 16'h0FFF, 1'b0);
    run_op("and",      4'b0011, 16'hFF00, 16'h0FF0, 16'h0F00, 1'b0);
    run_op("not",      4'b0110, 16'h975D, 16'h0000, 16'h68A2, 1'b0);
    run_op("asr4",     4'b1110, 16'h975D, 16'h0004, 16'hF975, 1'b0);
    run_op("lsr4",     4'b1010, 16'h975D, 16'h0004, 16'h0975, 1'b0);
    run_op("asl1",     4'b1100, 16'h975D, 16'h0001, 16'h2EBA, 1'b1);
    run_op("asl2_ok",  4'b1100, 16'hFFF3, 16'h0002, 16'hFFCC, 1'b0);
    run_op("lsl0",     4'b1000, 16'h975D, 16'h0000, 16'h975D, 1'b0);
    run_op("lsl4",     4'b1000, 16'h975D, 16'h0004, 16'h75D0, 1'b0);
    run_op("slte_eq",  4'b1001, 16'hCB95, 16'hCB95, 16'h0001, 1'b0);
    run_op("slte_gt",  4'b1001, 16'h55C6, 16'h175D, 16'h0000, 1'b0);
    run_op("slte_neg", 4'b1001, 16'hEB9D, 16'h55C6, 16'h0001, 1'b0);
    run_op("op0111",   4'b0111, 16'h1234, 16'h4321, 16'h0000, 1'b0);

    @(posedge clk); #1;
    check("drain_valid", bus.out_valid, 1'b0);

    // Backpressure: 5 back-to-back adds, OutReady low for 4 cycles at first OutValid.
    issued       = 0;
    recv         = 0;
    stall        = 0;
    seen         = 1'b0;
    held         = '0;
    bus.alu_ctrl = 4'b0001;
    bus.b        = 16'h0100;
    for (int cyc = 0; cyc < 40 && recv < 5; cyc++) begin
      bus.in_valid  = (issued < 5);
      bus.a         = 16'(issued);
      bus.out_ready = seen && (stall >= 4);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(16'(issued + 256));
        issued++;
      end
      if (bus.out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          held = bus.s;
        end
        if (bus.out_ready) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
          check("bp_order", bus.s, e);
          recv++;
        end else begin
          stall++;
          check("bp_hold",    bus.s,        held);
          check("bp_inready", bus.in_ready, 1'b0);
        end
      end else if (recv > 0) begin
        check("bp_gap", bus.out_valid, 1'b1);
      end
      @(posedge clk); #1;
    end
    check("bp_count", recv, 5);
    check("bp_stall", stall, 4);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_drain", bus.out_valid, 1'b0);

    // Reset mid-stream with a full pipeline.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.alu_ctrl  = 4'b0001;
    bus.a         = 16'h0005;
    bus.b         = 16'h0005;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mr_pre_valid", bus.out_valid, 1'b1);
    check("mr_pre_s",     bus.s,         16'h000A);
    #3 rst_n = 1'b0;
    #1;
    check("mr_valid", bus.out_valid, 1'b0);
    check("mr_s",     bus.s,         16'h0);
    check("mr_ovf",   bus.overflow,  1'b0);
    check("mr_zero",  bus.zero,      1'b0);
    check("mr_ready", bus.in_ready,  1'b1);
    bus.a = 16'h7777;
    @(posedge clk); #1;
    check("mr_hold_valid", bus.out_valid, 1'b0);
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("mr_nocapture", bus.out_valid, 1'b0);
    run_op("mr_add", 4'b0001, 16'h0001, 16'h0002, 16'h0003, 1'b0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("mr_nostale", bus.out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/param_alu_pipe.md
# param_alu_pipe

Parametrised, two-stage pipelined ALU with a valid/ready handshake on input and output. It executes the lab ALU opcode set at any operand width, adds variable-amount shifts and optional saturating arithmetic, and sits between an operand-issue stage and a result consumer that may apply backpressure.

## Interface
- WIDTH, 16, operand/result width in bits (≥ 4).
- SHW, $clog2(WIDTH), shift-amount width. Derived; do not override.
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  asynchronous, active-low reset.
- InValid  in  1  operand bundle valid.
- InReady  out  1  block can accept an operand bundle this cycle.
- A  in  WIDTH  operand A, two's complement.
- B  in  WIDTH  operand B; B[SHW-1:0] is the shift amount for shift ops.
- AluCtrl  in  4  opcode.
- OutValid  out  1  result valid.
- OutReady  in  1  consumer accepts result.
- S  out  WIDTH  result.
- Overflow  out  1  signed overflow for the result.
- Zero  out  1  S == 0.

## Operation
- Opcodes:
  - 0000 A−B
  - 0001 A+B
  - 0010 A|B
  - 0011 A&B
  - 0100 A−1
  - 0101 A+1
  - 0110 ~A
  - 1000 LSL A by B[SHW-1:0]
  - 1010 LSR
  - 1100 ASL
  - 1110 ASR (sign fill)
  - 1001 SLTE: S = 1 if signed A ≤ signed B, else 0
- Any other opcode: S = 0, Overflow = 0, Zero = 1.
- Overflow rules:
  - add/inc: operand signs equal and result sign differs.
  - sub/dec: A and subtrahend signs differ and result sign differs from A.
  - ASL: the result, arithmetically shifted back right by the same amount, does not equal A.
  - All other ops: 0.
- Shift amount 0 passes A through unchanged.
- Transfers occur only when Valid && Ready on the respective interface.
- Stage 1 registers A, B and the opcode. Stage 2 computes the result and registers S, Overflow and Zero.
- Stage advance rules:
  - Stage 2 loads when it is empty or OutReady = 1.
  - Stage 1 loads when it is empty or advancing.
  - InReady = !s1Valid || s2Advance (combinational).
- Results leave in acceptance order. None are dropped or duplicated.
- While OutValid && !OutReady, S, Overflow and Zero hold stable.

## Timing
- Latency: a bundle accepted at edge n gives OutValid = 1 after edge n+2 when there is no backpressure. Throughput is one result per cycle.
- Capacity: two bundles in flight. With OutReady held low, InReady falls after two acceptances and rises in the same cycle OutReady returns high.
- Simultaneous OutValid&&OutReady and InValid&&InReady with a full pipeline: both stages shift, with no bubble.
- Reset (async, mid-operation included):
  - All in-flight bundles are discarded.
  - OutValid = 0, S = 0, Overflow = 0, Zero = 0 immediately.
  - InReady reads 1 while Rst_n = 0, but no input is captured while Rst_n = 0.
  - First acceptance is possible on the first rising edge after Rst_n deasserts.
- No combinational path from A, B or AluCtrl to any output.

## Configuration
- ALU_SAT_EN defined: add, sub, inc and dec saturate on overflow, to 2^(WIDTH−1)−1 for positive overflow and −2^(WIDTH−1) for negative overflow. Overflow is still asserted. Zero reflects the saturated S.
- ALU_SAT_EN undefined: these ops wrap modulo 2^WIDTH. Shifts and logic ops are identical in both builds.

## Test plan
- Add 0x53DB + 0x55C6 (21,467 + 21,958), WIDTH=16:
  - without ALU_SAT_EN: S = 0xA9A1, Overflow = 1;
  - with ALU_SAT_EN: S = 0x7FFF, Overflow = 1.
  - OutValid rises 2 cycles after acceptance.
- Sub 0x175D − 0x175D: S = 0, Zero = 1, Overflow = 0. Dec 0x8000: S = 0x7FFF and Overflow = 1 without ALU_SAT_EN; S = 0x8000 and Overflow = 1 with it.
- Shifts on 0x975D:
  - ASR 4: S = 0xF975.
  - LSR 4: S = 0x0975.
  - ASL 1: S = 0x2EBA, Overflow = 1.
  - LSL 0: S = 0x975D.
- SLTE:
  - 0xCB95 vs 0xCB95: S = 1.
  - 0x55C6 vs 0x175D: S = 0.
  - 0xEB9D vs 0x55C6: S = 1.
  - Opcode 0111: S = 0, Zero = 1.
- Backpressure: issue 5 back-to-back adds with OutReady low for 4 cycles starting at the first OutValid.
  - InReady is 0 while two bundles are held.
  - S is stable during the stall.
  - All 5 results appear in order with no gaps once OutReady = 1.
- Reset mid-stream: drop Rst_n between clock edges while OutValid = 1.
  - OutValid and S clear before the next edge.
  - After release, a new add 1 + 2 yields S = 3 exactly 2 cycles after acceptance, with no stale results.
